// File: rtl/cic_dec_ctrl.sv
// Sequencer for a CIC decimator: paces integrator/comb updates, discards the
// settling comb outputs and buffers decimated results in a 2-deep FWFT FIFO.
module cic_dec_ctrl #(
   parameter int DW       = 16,
   parameter int RW       = 8,
   parameter int STAGES   = 3,
   parameter int COMB_LAT = 1
) (
   input  logic          cic_clk,
   input  logic          cic_rstn,
   input  logic          cfg_en,
   input  logic [RW-1:0] cfg_rate,
   input  logic          in_valid,
   output logic          int_clr,
   output logic          int_en,
   output logic          comb_en,
   input  logic [DW-1:0] comb_din,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          ovf,
   input  logic          ovf_clr,
   output logic [1:0]    state_o
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_WARMUP = 2'd2,
      ST_RUN    = 2'd3
   } state_e;

   localparam int WW = $clog2(STAGES + 1);
   localparam logic [RW-1:0] ZERO_R    = {RW{1'b0}};
   localparam logic [RW-1:0] ONE_R     = RW'(1'b1);
   localparam logic [RW-1:0] TWO_R     = RW'(2'd2);
   localparam logic [WW-1:0] ZERO_W    = {WW{1'b0}};
   localparam logic [WW-1:0] ONE_W     = WW'(1'b1);
   localparam logic [WW-1:0] LAST_WARM = WW'(STAGES - 1);

   state_e              state_q, state_d;
   logic [RW-1:0]       rate_q, rate_d;
   logic [RW-1:0]       phase_q, phase_d;
   logic [WW-1:0]       warm_q, warm_d;
   logic [COMB_LAT-1:0] dly_q, dly_d;
   logic [DW-1:0]       dout_q, dout_d;
   logic                dout_valid_q, dout_valid_d;
   logic [DW-1:0]       buf_q, buf_d;
   logic                buf_valid_q, buf_valid_d;
   logic                ovf_q, ovf_d;

   logic active_s;
   logic cap_s;
   logic push_s;
   logic pop_s;
   logic drop_s;

   assign active_s   = (state_q == ST_WARMUP) || (state_q == ST_RUN);
   assign int_en     = in_valid & active_s;
   assign comb_en    = int_en & (phase_q == (rate_q - ONE_R));
   assign int_clr    = (state_q == ST_FLUSH);
   assign cap_s      = dly_q[COMB_LAT-1];
   assign push_s     = cap_s & (state_q == ST_RUN);
   assign pop_s      = dout_valid_q & dout_ready;
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign ovf        = ovf_q;
   assign state_o    = state_q;

   // Next-state logic; dropping cfg_en wins from every state.
   always_comb begin
      state_d = state_q;
      if (!cfg_en) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:   state_d = ST_FLUSH;
            ST_FLUSH:  state_d = ST_WARMUP;
            ST_WARMUP: begin
               if (cap_s && (warm_q == LAST_WARM)) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_WARMUP;
               end
            end
            ST_RUN:    state_d = ST_RUN;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // Rate latch, decimation phase, warm-up count and comb latency pipe.
   always_comb begin
      rate_d  = rate_q;
      phase_d = phase_q;
      warm_d  = warm_q;
      dly_d   = dly_q;
      if (!cfg_en || (state_q == ST_FLUSH)) begin
         phase_d = ZERO_R;
         warm_d  = ZERO_W;
         dly_d   = {COMB_LAT{1'b0}};
      end else if (state_q == ST_IDLE) begin
         rate_d  = (cfg_rate < TWO_R) ? TWO_R : cfg_rate;
         phase_d = ZERO_R;
         warm_d  = ZERO_W;
         dly_d   = {COMB_LAT{1'b0}};
      end else begin
         dly_d[0] = comb_en;
         for (int i = 1; i < COMB_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
         end
         if (in_valid) begin
            phase_d = (phase_q == (rate_q - ONE_R)) ? ZERO_R : (phase_q + ONE_R);
         end else begin
            phase_d = phase_q;
         end
         if ((state_q == ST_WARMUP) && cap_s) begin
            warm_d = warm_q + ONE_W;
         end else begin
            warm_d = warm_q;
         end
      end
   end

   // Output FIFO: dout_q is the head, buf_q the second slot; pop before push
   // so a push into a full FIFO that is popped in the same cycle is kept.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      buf_d        = buf_q;
      buf_valid_d  = buf_valid_q;
      drop_s       = 1'b0;
      if (!cfg_en || (state_q == ST_FLUSH)) begin
         dout_valid_d = 1'b0;
         buf_valid_d  = 1'b0;
      end else begin
         if (pop_s) begin
            dout_d       = buf_valid_q ? buf_q : dout_q;
            dout_valid_d = buf_valid_q;
            buf_valid_d  = 1'b0;
         end else begin
            dout_valid_d = dout_valid_q;
         end
         if (push_s) begin
            if (!dout_valid_d) begin
               dout_d       = comb_din;
               dout_valid_d = 1'b1;
            end else if (!buf_valid_d) begin
               buf_d       = comb_din;
               buf_valid_d = 1'b1;
            end else begin
               drop_s = 1'b1;
            end
         end else begin
            drop_s = 1'b0;
         end
      end
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge cic_clk or negedge cic_rstn) begin
      if (!cic_rstn) begin
         state_q      <= ST_IDLE;
         rate_q       <= TWO_R;
         phase_q      <= ZERO_R;
         warm_q       <= ZERO_W;
         dly_q        <= {COMB_LAT{1'b0}};
         dout_q       <= {DW{1'b0}};
         dout_valid_q <= 1'b0;
         buf_q        <= {DW{1'b0}};
         buf_valid_q  <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         rate_q       <= rate_d;
         phase_q      <= phase_d;
         warm_q       <= warm_d;
         dly_q        <= dly_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         buf_q        <= buf_d;
         buf_valid_q  <= buf_valid_d;
         ovf_q        <= ovf_d;
      end
   end

endmodule
